// File: rtl/nn_axis_pkg.sv
// Shared state encoding and default frame geometry for the NN AXI-Stream frame sender.
package nn_axis_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} tx_state_e;

  localparam int IN_BEATS_DEF = 9;
  localparam int WB_BEATS_DEF = 10;
endpackage

// File: rtl/axis_tx_skid_fifo.sv
// Two-entry FIFO between the BRAM read port and the AXI-Stream master; head is the output beat.
module axis_tx_skid_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic [1:0]   count
);
  logic [1:0][W-1:0] mem;
  logic              wr_ptr, rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      // simultaneous push and pop leaves occupancy unchanged
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == 2'd0);
endmodule

// File: rtl/axis_nn_frame_tx.sv
// Streams one NN frame (input vector then weights/bias) from BRAM onto AXI-Stream.
// Define AXIS_FRAME_TX_TUSER_EN to add m_axis_tuser (1 on weight/bias beats).
module axis_nn_frame_tx
  import nn_axis_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int IN_BEATS   = IN_BEATS_DEF,
  parameter int WB_BEATS   = WB_BEATS_DEF
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
`ifdef AXIS_FRAME_TX_TUSER_EN
  ,
  output logic                  m_axis_tuser
`endif
);
  localparam int FRAME_LEN = IN_BEATS + WB_BEATS;
  localparam int CW        = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] WB_IDX   = CW'(IN_BEATS);

  tx_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0]         issue_cnt, beat_cnt;
  logic                  inflight, pop, empty;
  logic [1:0]            fifo_count;
  logic [2:0]            occ;

  axis_tx_skid_fifo #(.W(DATA_WIDTH)) u_fifo (
    .clk   (aclk),
    .rst   (areset),
    .push  (inflight),
    .pop   (pop),
    .din   (mem_dout),
    .dout  (m_axis_tdata),
    .empty (empty),
    .count (fifo_count)
  );

  assign m_axis_tvalid = ~empty;
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign m_axis_tlast  = m_axis_tvalid && (beat_cnt == LAST_IDX);
`ifdef AXIS_FRAME_TX_TUSER_EN
  assign m_axis_tuser  = m_axis_tvalid && (beat_cnt >= WB_IDX);
`endif
  // slots claimed after this edge; a read is issued only if one stays free
  assign occ      = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign mem_addr = addr_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    mem_en  = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = READ;
      READ: begin
        if (occ < 3'd2) begin
          mem_en = 1'b1;
          if (issue_cnt == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: if (pop && m_axis_tlast) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      addr_q    <= '0;
      issue_cnt <= '0;
      beat_cnt  <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= mem_en;
      if (state_q == IDLE && start) begin
        addr_q    <= base_addr;
        issue_cnt <= '0;
        beat_cnt  <= '0;
      end else begin
        if (mem_en) begin
          addr_q    <= addr_q + ADDR_WIDTH'(1);
          issue_cnt <= issue_cnt + CW'(1);
        end
        if (pop) beat_cnt <= beat_cnt + CW'(1);
      end
    end
  end
endmodule

// File: doc/axis_nn_frame_tx.md
AXIS_NN_FRAME_TX -- requirements
Module: axis_nn_frame_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: AXI-Stream and BRAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: BRAM address width.
REQ-003 SHALL have parameter IN_BEATS, default 9: input-vector beats per frame.
REQ-004 SHALL have parameter WB_BEATS, default 10: weight/bias beats per frame; the bias is the final beat.
REQ-005 SHALL have ports: aclk  in  1  clock; areset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: start  in  1  frame request; base_addr  in  ADDR_WIDTH  first BRAM word of the frame.
REQ-007 SHALL have ports: busy  out  1  frame in progress; done  out  1  one-cycle pulse, frame sent.
REQ-008 SHALL have ports: mem_en  out  1; mem_addr  out  ADDR_WIDTH; mem_dout  in  DATA_WIDTH. mem_dout is valid one cycle after mem_en.
REQ-009 SHALL have ports: m_axis_tdata  out  DATA_WIDTH; m_axis_tvalid  out  1; m_axis_tready  in  1; m_axis_tlast  out  1.

Function
REQ-010 SHALL implement the states IDLE, READ, DRAIN and DONE.
REQ-011 SHALL move IDLE->READ when start=1 in IDLE, latching base_addr; start outside IDLE SHALL be ignored.
REQ-012 SHALL, in READ, issue one mem_en per cycle while (fifo_count + inflight - pop) < 2, incrementing mem_addr each issue from base_addr, for FRAME_LEN = IN_BEATS + WB_BEATS issues in total.
REQ-013 SHALL move READ->DRAIN in the cycle after the final issue, and DRAIN->DONE on the handshake (tvalid and tready) of the beat carrying tlast.
REQ-014 SHALL spend exactly one cycle in DONE with done=1, then return to IDLE.
REQ-015 SHALL hold busy=1 in READ, DRAIN and DONE.
REQ-016 SHALL capture each returned mem_dout into a 2-entry FIFO; m_axis_tvalid = FIFO not empty, and m_axis_tdata = FIFO head.
REQ-017 SHALL pop the FIFO only on a tvalid-and-tready handshake; tdata, tvalid and tlast SHALL remain stable while tvalid=1 and tready=0.
REQ-018 SHALL assert m_axis_tlast only on beat FRAME_LEN-1, counted by a beat counter that advances on each handshake.
REQ-019 SHALL sustain one beat per cycle under continuous tready.
REQ-020 SHALL raise the first tvalid two cycles after start is sampled.
REQ-021 SHALL, in mem_addr arithmetic, wrap modulo 2^ADDR_WIDTH without error.
REQ-022 SHALL, when a FIFO push and pop occur in the same cycle, keep the FIFO count unchanged and preserve ordering.
REQ-023 SHALL never overflow the FIFO, given the issue rule of REQ-012.

Reset
REQ-024 SHALL, with areset=1 at any time including mid-frame: state=IDLE; counters, inflight and FIFO cleared; busy=0, done=0, mem_en=0, mem_addr=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
REQ-025 SHALL discard any partial frame on reset, with no tlast emitted.

Configuration
REQ-026 SHALL, when AXIS_FRAME_TX_TUSER_EN is defined, add port m_axis_tuser (out, 1): 0 on input beats 0..IN_BEATS-1 and 1 on weight/bias beats, stable while stalled, reset to 0.
REQ-027 SHALL, when AXIS_FRAME_TX_TUSER_EN is undefined, have no m_axis_tuser port, with all other behaviour identical.

Structure
REQ-028 SHALL take the state encoding and the default IN_BEATS/WB_BEATS constants from shared package nn_axis_pkg.
REQ-029 SHALL place the 2-entry FIFO in sub-module axis_tx_skid_fifo (push, pop, din, dout, empty, count).

Verification
REQ-030 SHALL cover: tready=1 throughout, base_addr=0, BRAM[i]=i -> beats 0..18 on consecutive cycles starting 2 cycles after start, tlast on beat 18 (data 18), done one cycle later.
REQ-031 SHALL cover: tready toggling 1/0 each cycle -> 19 beats in order with no drops or duplicates, data stable while stalled, tlast only on data 18.
REQ-032 SHALL cover: tready=0 for 10 cycles after start -> at most 2 reads outstanding, no overflow, and all 19 beats correct once tready=1.
REQ-033 SHALL cover: base_addr=28 with ADDR_WIDTH=5 -> reads at addresses 28..31 then 0..14.
REQ-034 SHALL cover: areset pulse at beat 7 -> all outputs at reset values immediately; a new start then sends a full 19-beat frame.
REQ-035 SHALL cover: start pulsed again while busy -> ignored, exactly one done; with AXIS_FRAME_TX_TUSER_EN defined, tuser=0 on beats 0..8 and 1 on beats 9..18.
